fft_bitrev_reorder: RTL and testbench
=====================================

Name: fft_bitrev_reorder

Overview:
Output-side reorder buffer for the SDF radix-2 FFT pipeline. The butterfly chain emits each N_POINTS frame in bit-reversed index order; this block accepts that stream and returns each frame in natural order. It uses two ping-pong frame banks so continuous input and continuous output run without stalls. A valid/ready handshake on the output lets downstream apply backpressure, which propagates to the input as in_rdy.

Parameters:
DATA_WIDTH, 16, width of each real/imaginary sample
N_POINTS, 16, FFT frame length; power of two, >= 4
ADDR_BITS, $clog2(N_POINTS), derived localparam; per-bank index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
in_val  in  1  input sample valid
in_rdy  out  1  block can accept a sample this cycle
in_re  in  DATA_WIDTH  real part, bit-reversed frame order
in_im  in  DATA_WIDTH  imaginary part, bit-reversed frame order
out_val  out  1  output register holds a valid sample
out_rdy  in  1  downstream accepts the output sample
out_re  out  DATA_WIDTH  real part, natural order
out_im  out  DATA_WIDTH  imaginary part, natural order
out_last  out  1  marks natural index N_POINTS-1 of a frame

Behaviour:
- Reset (rst low, async):
  - All outputs are 0: in_rdy, out_val, out_re, out_im, out_last.
  - Counters are 0, both bank-full flags clear, wr_bank = rd_bank = 0.
  - in_rdy rises in the first cycle after rst deasserts.
- Reset mid-frame discards partially written and partially read frames. Bank contents need not be cleared.
- Storage: two banks of N_POINTS x {re, im} registers, bank index 0/1.
- Write side:
  - in_rdy = ~full[wr_bank].
  - Accept on in_val & in_rdy. Store at bank[wr_bank][bitrev(wr_cnt)], then increment wr_cnt (ADDR_BITS wide).
  - Wrap: when wr_cnt == N_POINTS-1 is accepted, set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
  - in_val while in_rdy = 0 is ignored. No write occurs and the counter holds.
- Read side (output register):
  - Load condition: load = full[rd_bank] & (~out_val | out_rdy).
  - On load: out_re/out_im <= bank[rd_bank][rd_cnt], out_last <= (rd_cnt == N_POINTS-1), out_val <= 1, rd_cnt++.
  - On load with rd_cnt == N_POINTS-1: clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
  - If out_val & out_rdy and no load occurs: out_val <= 0, out_last <= 0.
  - While out_val & ~out_rdy: out_re, out_im and out_last hold stable.
- Simultaneous events:
  - A set of full[x] (write) and a clear of full[y] (read) in the same cycle is legal. If x == y, both are applied: a clear of full[x] releases that bank for its next frame, and the set marks the newly written frame. This case cannot occur by construction, because writes require ~full.
  - A read of bank x while bank 1-x is being written is always legal.
- Latency: the last sample of a frame is accepted on edge T. full is set at T, natural index 0 is loaded at T+1, and out_val is high from T+1.
- Throughput: with out_rdy held at 1, 1 sample/cycle indefinitely with no in_rdy deassertion. Bank x is freed at edge T+N_POINTS, before the next-but-one frame needs it at T+N_POINTS+1.
- Backpressure: with out_rdy = 0 for long enough, both banks fill and in_rdy = 0 until a bank drains.
- Arithmetic: no data arithmetic. Samples pass bit-exact.

Decomposition:
- Shared package fft_pkg:
  - function bitrev(idx, bits)
  - typedef cplx_t { logic [DATA_WIDTH-1:0] re, im; } for widths that are fixed at package level
  - FFT_N_POINTS default constant
- Single module, no sub-module. The bank array and the two pointer/counter pairs are small enough to live inline.

Test Plan:
- N_POINTS=16, out_rdy=1, feed in_re = k, in_im = 100+k for k = 0..15 contiguous -> out_re sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with in_im = out_re + 100; out_last only on the 16th; out_val first high at T+1.
- 4 back-to-back frames (64 samples), in_val and out_rdy = 1 throughout -> in_rdy never drops; 64 outputs contiguous; each frame reordered correctly.
- out_rdy = 0 while 2 full frames are sent -> in_rdy drops after sample 32; the 33rd in_val is ignored; out_val = 1 with out_re = 0 held stable. Raising out_rdy -> in_rdy rises within 1 cycle after the first bank drains (16 outputs).
- Random out_rdy (50%) and random in_val gaps over 20 frames -> scoreboard matches bitrev model with no drops or duplicates; out_last count = 20.
- Assert rst at sample 7 of frame 2 (mid-output of frame 1) -> out_val, in_rdy and out_last go 0 asynchronously. After release, a fresh frame k = 0..15 outputs in the exact order of the first scenario.
- N_POINTS=4 parameter run, input 0,1,2,3 -> output 0,2,1,3 with out_last on the 4th.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, the complex sample type and the
// bit-reversal helper used by the reorder stage.
package fft_pkg;

  localparam int FFT_N_POINTS   = 16;
  localparam int FFT_DATA_WIDTH = 16;

  typedef struct packed {
    logic [FFT_DATA_WIDTH-1:0] re;
    logic [FFT_DATA_WIDTH-1:0] im;
  } cplx_t;

  // Reverses the low 'bits' bits of idx; upper result bits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int bits);
    logic [31:0] src;
    logic [31:0] res;
    src = idx;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) begin
        res = {res[30:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes FFT frames in bit-reversed order and emits
// them in natural order through a registered valid/ready output stage.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int N_POINTS   = FFT_N_POINTS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_val,
  output logic                  in_rdy,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_last
);

  localparam int ADDR_BITS = $clog2(N_POINTS);
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(N_POINTS - 1);

  logic [1:0]           full_reg, full_next;
  logic                 wr_bank_reg, wr_bank_next;
  logic                 rd_bank_reg, rd_bank_next;
  logic [ADDR_BITS-1:0] wr_cnt_reg, wr_cnt_next;
  logic [ADDR_BITS-1:0] rd_cnt_reg, rd_cnt_next;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 wr_en;
  logic                 load;
  logic [DATA_WIDTH-1:0] bank_re [2];
  logic [DATA_WIDTH-1:0] bank_im [2];

  assign wr_en   = in_val & in_rdy;
  assign load    = full_reg[rd_bank_reg] & (~out_val | out_rdy);
  assign wr_addr = ADDR_BITS'(bitrev(32'(wr_cnt_reg), ADDR_BITS));

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] re_mem [N_POINTS];
    logic [DATA_WIDTH-1:0] im_mem [N_POINTS];

    always_ff @(posedge clk) begin
      if (wr_en && (wr_bank_reg == 1'(gi))) begin
        re_mem[wr_addr] <= in_re;
        im_mem[wr_addr] <= in_im;
      end
    end

    assign bank_re[gi] = re_mem[rd_cnt_reg];
    assign bank_im[gi] = im_mem[rd_cnt_reg];
  end

  // Read-side release is applied before the write-side set so a bank that
  // drains and refills on the same edge ends up marked full.
  always_comb begin
    full_next    = full_reg;
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    wr_cnt_next  = wr_cnt_reg;
    rd_cnt_next  = rd_cnt_reg;
    if (load) begin
      rd_cnt_next = rd_cnt_reg + ADDR_BITS'(1);
      if (rd_cnt_reg == LAST_IDX) begin
        full_next[rd_bank_reg] = 1'b0;
        rd_bank_next           = ~rd_bank_reg;
      end
    end
    if (wr_en) begin
      wr_cnt_next = wr_cnt_reg + ADDR_BITS'(1);
      if (wr_cnt_reg == LAST_IDX) begin
        full_next[wr_bank_reg] = 1'b1;
        wr_bank_next           = ~wr_bank_reg;
      end
    end
  end

  // in_rdy is registered from next state so it reads 0 throughout reset
  // and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_reg    <= '0;
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_cnt_reg  <= '0;
      rd_cnt_reg  <= '0;
      in_rdy      <= 1'b0;
      out_val     <= 1'b0;
      out_re      <= '0;
      out_im      <= '0;
      out_last    <= 1'b0;
    end else begin
      full_reg    <= full_next;
      wr_bank_reg <= wr_bank_next;
      rd_bank_reg <= rd_bank_next;
      wr_cnt_reg  <= wr_cnt_next;
      rd_cnt_reg  <= rd_cnt_next;
      in_rdy      <= ~full_next[wr_bank_next];
      if (load) begin
        out_re   <= bank_re[rd_bank_reg];
        out_im   <= bank_im[rd_bank_reg];
        out_last <= (rd_cnt_reg == LAST_IDX);
        out_val  <= 1'b1;
      end else if (out_val && out_rdy) begin
        out_val  <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomised self-checking bench for fft_bitrev_reorder (N=16 and N=4 instances)
// against a frame-level bit-reversal reference model.
module tb_fft_bitrev_reorder;
  import fft_pkg::*;

  typedef struct {
    cplx_t d;
    bit    last;
    int    cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_val = 1'b0, in_rdy, out_val, out_rdy = 1'b1, out_last;
  logic [15:0] in_re = '0, in_im = '0, out_re, out_im;
  logic        in_val4 = 1'b0, in_rdy4, out_val4, out_rdy4 = 1'b1, out_last4;
  logic [15:0] in_re4 = '0, in_im4 = '0, out_re4, out_im4;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int order16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  cplx_t cur_frame[$];
  cplx_t exp_q[$];
  obs_t  got_q[$];

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.DATA_WIDTH(16), .N_POINTS(16)) dut (
    .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_re(in_re), .in_im(in_im),
    .out_val(out_val), .out_rdy(out_rdy), .out_re(out_re), .out_im(out_im), .out_last(out_last)
  );

  fft_bitrev_reorder #(.DATA_WIDTH(16), .N_POINTS(4)) dut4 (
    .clk(clk), .rst(rst), .in_val(in_val4), .in_rdy(in_rdy4), .in_re(in_re4), .in_im(in_im4),
    .out_val(out_val4), .out_rdy(out_rdy4), .out_re(out_re4), .out_im(out_im4), .out_last(out_last4)
  );

  // Natural index n of a frame holds the sample that arrived at position rev(n).
  function automatic int rev_idx(input int k, input int n);
    int r = 0;
    int v = k;
    for (int b = 1; b < n; b = b * 2) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  function automatic cplx_t mk(input int re, input int im);
    cplx_t c;
    c.re = 16'(re);
    c.im = 16'(im);
    return c;
  endfunction

  function automatic cplx_t rnd();
    return mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
  endfunction

  function automatic void clear_model();
    cur_frame.delete();
    exp_q.delete();
    got_q.delete();
  endfunction

  // One clock of the N=16 instance, entered and left at a falling edge.
  // Records what the next rising edge will transfer on each side.
  task automatic tick(input bit v, input cplx_t d, input bit ordy, output bit acc);
    obs_t o;
    cplx_t c;
    in_val = v;
    in_re = d.re;
    in_im = d.im;
    out_rdy = ordy;
    #1;
    acc = v && in_rdy;
    if (acc) begin
      cur_frame.push_back(d);
      if (cur_frame.size() == 16) begin
        for (int n = 0; n < 16; n++) exp_q.push_back(cur_frame[rev_idx(n, 16)]);
        cur_frame.delete();
      end
    end
    if (out_val && ordy) begin
      c.re = out_re;
      c.im = out_im;
      o.d = c;
      o.last = out_last;
      o.cyc = cyc;
      got_q.push_back(o);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int want, input int budget);
    bit acc;
    int t = 0;
    while (got_q.size() < want && t < budget) begin
      tick(1'b0, mk(0, 0), 1'b1, acc);
      t++;
    end
    n_checks++;
    if (got_q.size() != want) begin
      n_fail++;
      $display("FAIL drain_count: got %0d outputs, required %0d", got_q.size(), want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_rdy, out_val, out_last, out_re, out_im} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b val=%b last=%b re=%h im=%h, required all 0",
               in_rdy, out_val, out_last, out_re, out_im);
    end
    n_checks++;
    if ({in_rdy4, out_val4, out_last4} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs_n4: rdy/val/last=%b, required 000", {in_rdy4, out_val4, out_last4});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_rdy: in_rdy=%b before first edge, required 0", in_rdy);
    end
    @(negedge clk);
    n_checks++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rdy_rise: in_rdy=%b after first edge, required 1", in_rdy);
    end
  endtask

  task automatic test_single_frame(input string tag);
    bit acc;
    int nacc = 0;
    clear_model();
    for (int k = 0; k < 16; k++) begin
      tick(1'b1, mk(k, 100 + k), 1'b1, acc);
      if (acc) nacc++;
    end
    n_checks++;
    if (nacc != 16) begin
      n_fail++;
      $display("FAIL %s_accept: accepted %0d, required 16", tag, nacc);
    end
    n_checks++;
    if (out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_latency_T: out_val=%b at T, required 0", tag, out_val);
    end
    tick(1'b0, mk(0, 0), 1'b0, acc);
    n_checks++;
    if (out_val !== 1'b1 || out_re !== 16'd0) begin
      n_fail++;
      $display("FAIL %s_latency_T1: out_val=%b out_re=%0d at T+1, required 1 and 0", tag, out_val, out_re);
    end
    drain(16, 40);
    for (int i = 0; i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d.re !== 16'(order16[i]) || got_q[i].d.im !== 16'(order16[i] + 100) ||
          got_q[i].last !== (i == 15)) begin
        n_fail++;
        $display("FAIL %s_order[%0d]: re=%0d im=%0d last=%b, required re=%0d im=%0d last=%b",
                 tag, i, got_q[i].d.re, got_q[i].d.im, got_q[i].last,
                 order16[i], order16[i] + 100, i == 15);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int sent = 0;
    int stalls = 0;
    clear_model();
    while (sent < 64 && stalls < 100) begin
      tick(1'b1, rnd(), 1'b1, acc);
      if (acc) sent++;
      else stalls++;
    end
    n_checks++;
    if (stalls != 0) begin
      n_fail++;
      $display("FAIL b2b_in_rdy: %0d stall cycles, required 0", stalls);
    end
    drain(64, 100);
    n_checks++;
    if (got_q.size() == 64 && got_q[63].cyc - got_q[0].cyc != 63) begin
      n_fail++;
      $display("FAIL b2b_contiguous: span %0d cycles, required 63", got_q[63].cyc - got_q[0].cyc);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i] || got_q[i].last !== (i % 16 == 15)) begin
        n_fail++;
        $display("FAIL b2b_data[%0d]: got %h last=%b, required %h last=%b",
                 i, got_q[i].d, got_q[i].last, exp_q[i], i % 16 == 15);
      end
    end
  endtask

  task automatic test_backpressure();
    bit acc;
    int t = 0;
    int nacc = 0;
    clear_model();
    for (int i = 0; i < 33; i++) begin
      tick(1'b1, mk(i, 500 + i), 1'b0, acc);
      if (acc) nacc++;
      if (i == 32) begin
        n_checks++;
        if (acc) begin
          n_fail++;
          $display("FAIL bp_33rd_ignored: 33rd sample accepted, required ignored");
        end
      end
    end
    n_checks++;
    if (nacc != 32 || in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_fill: accepted %0d in_rdy=%b, required 32 and 0", nacc, in_rdy);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, mk(0, 0), 1'b0, acc);
      n_checks++;
      if (out_val !== 1'b1 || out_re !== 16'd0 || out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: val=%b re=%0d last=%b, required 1 0 0", out_val, out_re, out_last);
      end
    end
    while (got_q.size() < 16 && t < 50) begin
      if (got_q.size() <= 13) begin
        n_checks++;
        if (in_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_rdy_early: in_rdy=%b after %0d outputs, required 0", in_rdy, got_q.size());
        end
      end
      tick(1'b0, mk(0, 0), 1'b1, acc);
      t++;
    end
    n_checks++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_rdy_rise: in_rdy=%b after first bank drained, required 1", in_rdy);
    end
    drain(32, 60);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i].d !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bp_data[%0d]: got %h, required %h", i, got_q[i].d, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit acc;
    bit v;
    int sent = 0;
    int t = 0;
    int lasts = 0;
    clear_model();
    while ((sent < 320 || got_q.size() < 320) && t < 6000) begin
      v = (sent < 320) && ($urandom_range(0, 3) != 0);
      tick(v, rnd(), 1'($urandom_range(0, 1)), acc);
      if (acc) sent++;
      t++;
    end
    n_checks++;
    if (got_q.size() != 320 || exp_q.size() != 320) begin
      n_fail++;
      $display("FAIL rand_count: got %0d expected-model %0d, required 320", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i].last) lasts++;
      n_checks++;
      if (got_q[i].d !== exp_q[i] || got_q[i].last !== (i % 16 == 15)) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got %h last=%b, required %h last=%b",
                 i, got_q[i].d, got_q[i].last, exp_q[i], i % 16 == 15);
      end
    end
    n_checks++;
    if (lasts != 20) begin
      n_fail++;
      $display("FAIL rand_last_count: %0d, required 20", lasts);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit acc;
    clear_model();
    for (int i = 0; i < 23; i++) tick(1'b1, mk(i, 300 + i), 1'b1, acc);
    n_checks++;
    if (out_val !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: out_val=%b mid-output, required 1", out_val);
    end
    in_val = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({in_rdy, out_val, out_last, out_re, out_im} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: rdy=%b val=%b last=%b re=%h im=%h, required all 0",
               in_rdy, out_val, out_last, out_re, out_im);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_release: in_rdy=%b out_val=%b, required 1 and 0", in_rdy, out_val);
    end
    test_single_frame("midrst_frame");
  endtask

  task automatic test_n4();
    int got = 0;
    int k = 0;
    int t = 0;
    while (got < 4 && t < 40) begin
      in_val4 = (k < 4);
      in_re4 = 16'(k);
      in_im4 = 16'(k + 40);
      out_rdy4 = 1'b1;
      #1;
      if (in_val4 && in_rdy4) k++;
      if (out_val4) begin
        n_checks++;
        if (out_re4 !== 16'(rev_idx(got, 4)) || out_im4 !== 16'(rev_idx(got, 4) + 40) ||
            out_last4 !== (got == 3)) begin
          n_fail++;
          $display("FAIL n4_out[%0d]: re=%0d im=%0d last=%b, required re=%0d im=%0d last=%b",
                   got, out_re4, out_im4, out_last4, rev_idx(got, 4), rev_idx(got, 4) + 40, got == 3);
        end
        got++;
      end
      @(negedge clk);
      t++;
    end
    in_val4 = 1'b0;
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL n4_count: %0d outputs, required 4", got);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_frame("single");
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid_frame();
    test_n4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
